cbus_arbiter: RTL and testbench

//  Shares one downstream CBus port among NUM_INPUTS upstream requesters.

---
 rtl/cbus_arbiter_pkg.sv | 32 +++
 rtl/cbus_arbiter_rr_pick.sv | 36 +++
 rtl/cbus_arbiter.sv | 82 ++++++++
 tb/tb_cbus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus request/response types and arbiter state encoding.
// Imported by the arbiter top and its round-robin picker.
package cbus_arbiter_pkg;

   localparam int CBUS_ADDR_W = 32;
   localparam int CBUS_DATA_W = 32;
   localparam int CBUS_LEN_W  = 8;

   typedef struct packed {
      logic                     valid;
      logic                     is_write;
      logic [2:0]               size;
      logic [CBUS_ADDR_W-1:0]   addr;
      logic [CBUS_DATA_W/8-1:0] strobe;
      logic [CBUS_DATA_W-1:0]   data;
      logic [CBUS_LEN_W-1:0]    len;
   } cbus_req_t;

   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [CBUS_DATA_W-1:0] data;
   } cbus_resp_t;

   typedef enum logic {CBUS_ARB_IDLE, CBUS_ARB_BUSY} cbus_arb_state_t;

   // Grant index width; a single requester still needs a 1-bit index.
   function automatic int cbus_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid found scanning
// ptr, ptr+1, ... with wrap modulo N.
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand_idx [N];
   logic [N-1:0]     cand_valid;

   // Candidate gi is the index visited gi steps after ptr.
   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum            = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi]   = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                     : IDX_W'(sum);
      assign cand_valid[gi] = valid[cand_idx[gi]];
   end

   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            any = 1'b1;
            idx = cand_idx[k];
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter: one requester owns the downstream port for a whole
// locked burst; one IDLE cycle separates consecutive grants.
module cbus_arbiter
   import cbus_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_INPUTS],
   output cbus_resp_t iresps [NUM_INPUTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int IDX_W = cbus_idx_w(NUM_INPUTS);

   cbus_arb_state_t  state_reg, state_next;
   logic [IDX_W-1:0] sel_reg, sel_next;
   logic [IDX_W-1:0] ptr_reg, ptr_next;

   logic [NUM_INPUTS-1:0] valid_vec;
   logic                  pick_any;
   logic [IDX_W-1:0]      pick_idx;
   logic                  busy;

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
      assign valid_vec[gi] = ireqs[gi].valid;
   end

   rr_pick #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .valid (valid_vec),
      .ptr   (ptr_reg),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         CBUS_ARB_IDLE: begin
            if (pick_any) begin
               state_next = CBUS_ARB_BUSY;
               sel_next   = pick_idx;
            end
         end
         CBUS_ARB_BUSY: begin
            // Hold the grant until the slave ends the burst, regardless of valid.
            if (oresp.ready && oresp.last) begin
               state_next = CBUS_ARB_IDLE;
               ptr_next   = (sel_reg == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_reg + 1'b1;
            end
         end
         default: state_next = CBUS_ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= CBUS_ARB_IDLE;
         sel_reg   <= '0;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign busy = (state_reg == CBUS_ARB_BUSY);
   assign oreq = busy ? ireqs[sel_reg] : '0;

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_resp
      assign iresps[gi] = (busy && (sel_reg == IDX_W'(gi))) ? oresp : '0;
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized scoreboard bench for cbus_arbiter with three requesters and a
// behavioural round-robin model predicting every grant.
`timescale 1ns/1ps
module tb_cbus_arbiter;
   import cbus_arbiter_pkg::*;

   localparam int N = 3;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   cbus_req_t  ireqs_drv  [N];
   cbus_resp_t iresps_dut [N];
   cbus_req_t  oreq_dut;
   cbus_resp_t oresp_drv;

   always #5 clk = ~clk;

   cbus_arbiter #(.NUM_INPUTS(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs_drv),
      .iresps (iresps_dut),
      .oreq   (oreq_dut),
      .oresp  (oresp_drv)
   );

   typedef struct {
      int        sel;
      cbus_req_t req;
   } grant_t;

   grant_t    exp_q [$];
   cbus_req_t req_q [N][$];

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit m_busy = 0;
   int m_sel  = 0;
   int m_ptr  = 0;

   // slave state
   int beat        = 0;
   int stall_force = 0;
   int stall_pct   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cbus_req_t make_txn(input bit wr, input int len);
      cbus_req_t t;
      t          = '0;
      t.valid    = 1'b1;
      t.is_write = wr;
      t.size     = 3'd2;
      t.addr     = $urandom & 32'hffff_fffc;
      t.strobe   = wr ? 4'hf : 4'h0;
      t.data     = $urandom;
      t.len      = 8'(len);
      return t;
   endfunction

   // One clock: model step at the edge, then requesters, then the slave.
   task automatic cycle();
      @(posedge clk);
      if (reset) begin
         m_busy = 0;
         m_ptr  = 0;
         beat   = 0;
         exp_q.delete();
      end else begin
         if (oresp_drv.ready) beat = oresp_drv.last ? 0 : beat + 1;
         if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               int   i;
               grant_t g;
               i = (m_ptr + k) % N;
               if (ireqs_drv[i].valid) begin
                  m_busy = 1;
                  m_sel  = i;
                  g.sel  = i;
                  g.req  = ireqs_drv[i];
                  exp_q.push_back(g);
                  break;
               end
            end
         end else if (oresp_drv.ready && oresp_drv.last) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % N;
            if (req_q[m_sel].size() > 0) void'(req_q[m_sel].pop_front());
         end
      end
      #1;
      for (int i = 0; i < N; i++)
         ireqs_drv[i] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
      #1;
      oresp_drv = '0;
      if (!reset && oreq_dut.valid) begin
         oresp_drv.data = $urandom;
         if (stall_force > 0) begin
            stall_force--;
            oresp_drv.ready = 1'b0;
         end else begin
            oresp_drv.ready = ($urandom_range(0, 99) >= stall_pct);
         end
         oresp_drv.last = oresp_drv.ready && (beat == int'(oreq_dut.len));
      end
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy;
      for (int i = 0; i < N; i++) if (req_q[i].size() > 0) p = 1;
      return p;
   endfunction

   task automatic drain(input string name, input int max_cycles);
      int c;
      c = 0;
      while (pending() && c < max_cycles) begin
         cycle();
         c++;
      end
      cycle();
      check({name, "_drained"}, 128'(pending()), 128'(0));
   endtask

   task automatic do_reset(input int hold);
      reset     = 1'b1;
      oresp_drv = '0;
      for (int i = 0; i < N; i++) begin
         req_q[i].delete();
         ireqs_drv[i] = '0;
      end
      repeat (hold) cycle();
      reset = 1'b0;
   endtask

   // Monitor: pops the predicted grant whenever one is due and checks the routing.
   initial begin
      bit     active;
      int     cur;
      grant_t g;
      active = 0;
      cur    = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("reset_oreq", 128'(oreq_dut), 128'(0));
            for (int i = 0; i < N; i++) check("reset_iresp", 128'(iresps_dut[i]), 128'(0));
            active = 0;
            continue;
         end
         if (!active) begin
            if (exp_q.size() > 0) begin
               g      = exp_q.pop_front();
               cur    = g.sel;
               active = 1;
               check("grant_req", 128'(oreq_dut), 128'(g.req));
               $display("txn: grant req%0d %s addr=%h len=%0d t=%0t", g.sel,
                        g.req.is_write ? "wr" : "rd", g.req.addr, g.req.len, $time);
            end else begin
               check("idle_oreq", 128'(oreq_dut), 128'(0));
               for (int i = 0; i < N; i++) check("idle_iresp", 128'(iresps_dut[i]), 128'(0));
            end
         end
         if (active) begin
            check("oreq_pass", 128'(oreq_dut), 128'(ireqs_drv[cur]));
            for (int i = 0; i < N; i++)
               check("iresp_route", 128'(iresps_dut[i]), (i == cur) ? 128'(oresp_drv) : 128'(0));
            if (oresp_drv.ready && oresp_drv.last) active = 0;
         end
      end
   end

   initial begin
      int c;
      for (int i = 0; i < N; i++) ireqs_drv[i] = '0;
      oresp_drv = '0;

      // reset, then quiet bus
      do_reset(3);
      repeat (10) cycle();

      // lone single-beat read on req1
      req_q[1].push_back(make_txn(1'b0, 0));
      drain("single", 50);

      // reset while a burst is in flight, then ptr must restart at 0
      req_q[1].push_back(make_txn(1'b1, 3));
      stall_force = 2;
      c = 0;
      while (!m_busy && c < 20) begin cycle(); c++; end
      cycle();
      do_reset(2);
      cycle();
      req_q[1].push_back(make_txn(1'b0, 0));
      req_q[0].push_back(make_txn(1'b0, 0));
      drain("after_reset", 50);

      // alternating grants with both holding valid
      do_reset(1);
      for (int t = 0; t < 4; t++) begin
         req_q[0].push_back(make_txn(t[0], t % 3));
         req_q[1].push_back(make_txn(~t[0], (t + 1) % 3));
      end
      drain("alternate", 300);

      // req1 arrives in the middle of a locked req0 burst
      req_q[0].push_back(make_txn(1'b1, 3));
      stall_pct = 40;
      c = 0;
      while (!(m_busy && m_sel == 0) && c < 20) begin cycle(); c++; end
      cycle();
      req_q[1].push_back(make_txn(1'b0, 0));
      drain("mid_burst", 200);
      stall_pct = 0;

      // ptr=1 with req2 and req0 valid together
      do_reset(1);
      req_q[0].push_back(make_txn(1'b0, 0));
      drain("set_ptr", 50);
      req_q[2].push_back(make_txn(1'b0, 1));
      req_q[0].push_back(make_txn(1'b1, 0));
      drain("wrap", 100);

      // downstream stall during a write while others wait
      stall_force = 5;
      req_q[2].push_back(make_txn(1'b1, 1));
      cycle();
      req_q[0].push_back(make_txn(1'b0, 0));
      req_q[1].push_back(make_txn(1'b0, 2));
      drain("stall", 200);

      // random traffic
      stall_pct = 30;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            int r;
            r = $urandom_range(0, N - 1);
            if (req_q[r].size() < 3)
               req_q[r].push_back(make_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3)));
         end
         cycle();
      end
      drain("random", 3000);

      repeat (2) cycle();
      check("grants_consumed", 128'(exp_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
